// File: rtl/alu_pkg.sv
// Shared widths and FSM encoding for the sequential divider.
// Signed support in seq_divider is compiled only with SEQ_DIVIDER_SIGNED_EN.
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int STEP_CNT_W = 6;

  localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference or restore.
module div_step
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic [DATA_W-1:0] next_quo
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;
  logic            borrow;
  logic            unused_diff_msb;

  // The partial remainder is 33 bits wide; the extra top bit of the result is the borrow.
  assign partial = {rem, quo[DATA_W-1]};
  assign {borrow, diff} = {1'b0, partial} - {2'b00, divisor};

  assign next_rem = borrow ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
  assign next_quo = {quo[DATA_W-2:0], ~borrow};

  assign unused_diff_msb = diff[DATA_W];

endmodule

// File: rtl/seq_divider.sv
// Sequential 32-bit restoring divider with fixed 33-cycle latency.
// Define SEQ_DIVIDER_SIGNED_EN to add two's-complement operation via signed_op.
module seq_divider
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              signed_op,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic              overflow
);

  div_state_t            state, next_state;
  logic [STEP_CNT_W-1:0] count;
  logic [DATA_W-1:0]     rem_r, quo_r, divisor_r;
  logic [DATA_W-1:0]     step_rem, step_quo;
  logic [DATA_W-1:0]     dividend_mag, divisor_mag;
  logic                  accept;

  div_step u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == RUN) || (state == FIXUP);
  assign done   = (state == DONE);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic              dividend_neg, divisor_neg;
  logic              neg_quo, neg_rem, ovf_pend;
  logic [DATA_W-1:0] dividend_raw;

  assign dividend_neg = signed_op && dividend[DATA_W-1];
  assign divisor_neg  = signed_op && divisor[DATA_W-1];
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg  ? -divisor  : divisor;
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign dividend_mag     = dividend;
  assign divisor_mag      = divisor;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == LAST_STEP) next_state = FIXUP;
      FIXUP:   next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in RUN, publish results on FIXUP->DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      divisor_r   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      ovf_pend     <= 1'b0;
      dividend_raw <= '0;
`endif
    end else if (accept) begin
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= dividend_mag;
      divisor_r   <= divisor_mag;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo      <= dividend_neg ^ divisor_neg;
      neg_rem      <= dividend_neg;
      ovf_pend     <= signed_op && (dividend == {1'b1, {(DATA_W-1){1'b0}}}) &&
                      (divisor == {DATA_W{1'b1}});
      dividend_raw <= dividend;
`endif
    end else if (state == RUN) begin
      rem_r <= step_rem;
      quo_r <= step_quo;
      if (count != LAST_STEP) count <= count + 1'b1;
    end else if (state == FIXUP) begin
      div_by_zero <= (divisor_r == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (divisor_r == '0) begin
        quotient  <= '1;
        remainder <= dividend_raw;
      end else begin
        quotient  <= neg_quo ? -quo_r : quo_r;
        remainder <= neg_rem ? -rem_r : rem_r;
        overflow  <= ovf_pend;
      end
`else
      // Restoring division by zero naturally yields all-ones and the dividend.
      quotient  <= quo_r;
      remainder <= rem_r;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus random operands
// against an arithmetic reference model. Signed cases need SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        signed_op = 1'b0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero, overflow;

  int checks = 0;
  int failures = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    sa = a;
    sb = b;
    if (b == 0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q  = 32'h8000_0000;
        r  = 0;
        ov = 1'b1;
      end else if (s) begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      if (s && sa == sb && sa == 0) q = q;
`endif
    end
  endfunction

  // Accepting edge is the posedge inside this task; returns 1 time unit after it.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== 68'd0) begin
      failures++;
      $display("FAIL reset_outputs got q=%h r=%h busy=%b done=%b dz=%b ov=%b exp all zero",
               quotient, remainder, busy, done, div_by_zero, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int e;
    launch(32'd100, 32'd7, 1'b0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(e);
    checks++;
    if (e !== 33) begin failures++; $display("FAIL basic_latency got=%0d exp=33", e); end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      failures++;
      $display("FAIL basic_result got q=%0d r=%0d exp q=14 r=2", quotient, remainder);
    end
    checks++;
    if (div_by_zero !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_flags got dz=%b ov=%b busy=%b exp 0 0 0", div_by_zero, overflow, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_div_by_zero;
    int e;
    launch(32'h1234_5678, 32'd0, 1'b0);
    wait_done(e);
    checks++;
    if (e !== 33) begin failures++; $display("FAIL dbz_latency got=%0d exp=33", e); end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_result got q=%h r=%h dz=%b exp q=ffffffff r=12345678 dz=1",
               quotient, remainder, div_by_zero);
    end
    // A fresh accept must clear the flag before results are published.
    launch(32'd9, 32'd3, 1'b0);
    checks++;
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_clear got=%b exp=0", div_by_zero); end
    wait_done(e);
  endtask

  task automatic test_ignored_start;
    int first_edge = -1;
    int done_count = 0;
    logic [31:0] q_at_done = '0, r_at_done = '0;
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk);
      if (e == 10) begin
        dividend = 32'd5;
        divisor  = 32'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        done_count++;
        if (first_edge < 0) begin
          first_edge = e;
          q_at_done  = quotient;
          r_at_done  = remainder;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first_edge !== 33 || done_count !== 1) begin
      failures++;
      $display("FAIL ignored_start_done got edge=%0d count=%0d exp edge=33 count=1", first_edge, done_count);
    end
    checks++;
    if (q_at_done !== 32'hFFFF_FFFF || r_at_done !== 32'd0) begin
      failures++;
      $display("FAIL ignored_start_result got q=%h r=%h exp q=ffffffff r=0", q_at_done, r_at_done);
    end
    checks++;
    if (quotient !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL ignored_start_hold got q=%h exp=ffffffff", quotient);
    end
  endtask

  task automatic test_reset_abort;
    int e;
    launch(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 15; k++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== 68'd0) begin
      failures++;
      $display("FAIL abort_outputs got q=%h r=%h busy=%b done=%b dz=%b ov=%b exp all zero",
               quotient, remainder, busy, done, div_by_zero, overflow);
    end
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_first_edge_accept got busy=%b exp=1", busy); end
    wait_done(e);
    checks++;
    if (e !== 33) begin failures++; $display("FAIL abort_latency got=%0d exp=33", e); end
    checks++;
    if (quotient !== 32'd2 || remainder !== 32'd1) begin
      failures++;
      $display("FAIL abort_result got q=%0d r=%0d exp q=2 r=1", quotient, remainder);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er;
    logic s, edz, eov;
    int e;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      ref_div(a, b, s, eq, er, edz, eov);
      launch(a, b, s);
      wait_done(e);
      checks++;
      if (e !== 33 || quotient !== eq || remainder !== er || div_by_zero !== edz || overflow !== eov) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h s=%b got edge=%0d q=%h r=%h dz=%b ov=%b exp edge=33 q=%h r=%h dz=%b ov=%b",
                 i, a, b, s, e, quotient, remainder, div_by_zero, overflow, eq, er, edz, eov);
      end
    end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed;
    int e;
    launch(-32'sd7, 32'd2, 1'b1);
    wait_done(e);
    checks++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF || overflow !== 1'b0) begin
      failures++;
      $display("FAIL signed_neg7_by_2 got q=%h r=%h ov=%b exp q=fffffffd r=ffffffff ov=0",
               quotient, remainder, overflow);
    end
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(e);
    checks++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || overflow !== 1'b1 || e !== 33) begin
      failures++;
      $display("FAIL signed_overflow got q=%h r=%h ov=%b edge=%0d exp q=80000000 r=0 ov=1 edge=33",
               quotient, remainder, overflow, e);
    end
    launch(32'hFFFF_FFF0, 32'd0, 1'b1);
    wait_done(e);
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFF0 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL signed_dbz got q=%h r=%h dz=%b exp q=ffffffff r=fffffff0 dz=1",
               quotient, remainder, div_by_zero);
    end
  endtask
`endif

  task automatic test_back_to_back;
    int e1, e2;
    @(negedge clk);
    dividend  = 32'd1000;
    divisor   = 32'd33;
    signed_op = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    wait_done(e1);
    checks++;
    if (e1 !== 33 || quotient !== 32'd30 || remainder !== 32'd10) begin
      failures++;
      $display("FAIL b2b_first got edge=%0d q=%0d r=%0d exp edge=33 q=30 r=10", e1, quotient, remainder);
    end
    @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_bubble got busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    wait_done(e2);
    checks++;
    if (e2 + 1 !== 34 || quotient !== 32'd9 || remainder !== 32'd5) begin
      failures++;
      $display("FAIL b2b_second got spacing=%0d q=%0d r=%0d exp spacing=34 q=9 r=5", e2 + 1, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_ignored_start();
    test_reset_abort();
    test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
